// File: rtl/output_port_allocator_if.sv
// ---------------------------------------------------------------------------
// output_port_allocator_if : request/grant/credit bundle for one output port
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

interface output_port_allocator_if #(
  parameter int NUM_IN = 5,
  parameter int CW     = 3
);
  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   empty;
  logic [3*NUM_IN-1:0] flit_id;
  logic                credit_in;
  logic [NUM_IN-1:0]   grant;
  logic [NUM_IN-1:0]   rd_en;
  logic                busy;
  logic [CW-1:0]       credit_cnt;
  logic                credit_err;

  modport master (
    output req, empty, flit_id, credit_in,
    input  grant, rd_en, busy, credit_cnt, credit_err
  );

  modport slave (
    input  req, empty, flit_id, credit_in,
    output grant, rd_en, busy, credit_cnt, credit_err
  );
endinterface

`default_nettype wire

// File: rtl/output_port_allocator.sv
// ---------------------------------------------------------------------------
// output_port_allocator : packet-granular round-robin allocator with credits
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module output_port_allocator #(
  parameter int NUM_IN  = 5,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  wire logic               clk,
  input  wire logic               rst,
  output_port_allocator_if.slave  bus
);

  localparam int                c_ptr_w   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [c_ptr_w:0]  c_num_in  = (c_ptr_w+1)'(NUM_IN);
  localparam logic [CW-1:0]     c_credits = CW'(CREDITS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_IN-1:0]   r_grant, w_grant_nxt;
  logic [c_ptr_w-1:0]  r_ptr, w_ptr_nxt;
  logic [CW-1:0]       r_credit;
  logic                r_err;

  logic [NUM_IN-1:0]   w_elig, w_tail, w_rot, w_rd_en;
  logic [c_ptr_w-1:0]  w_win;
  logic                w_found, w_has_credit, w_pop, w_tail_pop;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_flit
    assign w_elig[i] = bus.req[i] & ~bus.empty[i] & (bus.flit_id[3*i +: 3] == `HEADER);
    assign w_tail[i] = (bus.flit_id[3*i +: 3] == `TAIL);
  end

  assign w_has_credit = (r_credit != '0);
  assign w_rd_en      = (r_state == ST_LOCKED && w_has_credit) ? (r_grant & ~bus.empty) : '0;
  assign w_pop        = |w_rd_en;
  assign w_tail_pop   = |(w_rd_en & w_tail);

  // Rotate so bit 0 is the pointer position; first set bit is the winner offset.
  assign w_rot = NUM_IN'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    logic [c_ptr_w:0] v_sum;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        v_sum   = {1'b0, r_ptr} + (c_ptr_w+1)'(k);
        if (v_sum >= c_num_in) v_sum = v_sum - c_num_in;
        w_win   = v_sum[c_ptr_w-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_found && w_has_credit) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = NUM_IN'(1) << w_win;
          w_ptr_nxt   = (w_win == c_ptr_w'(NUM_IN-1)) ? '0 : w_win + c_ptr_w'(1);
        end
      end
      ST_LOCKED: begin
        if (w_tail_pop) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // A returned credit and a pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= c_credits;
      r_err    <= 1'b0;
    end else begin
      case ({bus.credit_in, w_pop})
        2'b10: begin
          if (r_credit == c_credits) r_err    <= 1'b1;
          else                       r_credit <= r_credit + CW'(1);
        end
        2'b01:   r_credit <= r_credit - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.rd_en      = w_rd_en;
  assign bus.busy       = (r_state == ST_LOCKED);
  assign bus.credit_cnt = r_credit;
  assign bus.credit_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_output_port_allocator.sv
// ---------------------------------------------------------------------------
// tb_output_port_allocator : directed scoreboard bench for output_port_allocator
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_output_port_allocator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  output_port_allocator_if #(.NUM_IN(5), .CW(3)) bus ();

  output_port_allocator #(.NUM_IN(5), .CREDITS(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] g;
    logic [4:0] rd;
    logic       b;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [2:0] H = `HEADER;
  localparam logic [2:0] P = `PAYLOAD;
  localparam logic [2:0] T = `TAIL;
  localparam logic [2:0] N = 3'b000;

  function automatic logic [14:0] fv(input logic [2:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic drive(input logic [4:0] r, input logic [4:0] e, input logic [14:0] f,
                       input logic ci, input logic rs);
    bus.req       = r;
    bus.empty     = e;
    bus.flit_id   = f;
    bus.credit_in = ci;
    rst           = rs;
  endtask

  // Expected outputs for the cycle just driven; checked mid-cycle, then advance.
  task automatic step(input string tag, input logic [4:0] g, input logic [4:0] rd,
                      input logic b, input logic [2:0] c, input logic e);
    exp_t x;
    x.tag = tag; x.g = g; x.rd = rd; x.b = b; x.c = c; x.e = e;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    n_cmp++;
    assert ({bus.grant, bus.rd_en, bus.busy, bus.credit_cnt, bus.credit_err} ===
            {x.g, x.rd, x.b, x.c, x.e})
    else begin
      n_bad++;
      $error("FAIL %s: got grant=%b rd_en=%b busy=%b credit_cnt=%0d credit_err=%b, want grant=%b rd_en=%b busy=%b credit_cnt=%0d credit_err=%b",
             x.tag, bus.grant, bus.rd_en, bus.busy, bus.credit_cnt, bus.credit_err,
             x.g, x.rd, x.b, x.c, x.e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(5'b00000, 5'b11111, 15'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    step("reset", 5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);

    // single packet on input 1
    drive(5'b00010, 5'b11101, fv(N, H, N, N, N), 1'b0, 1'b0); step("t1_idle",  5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b00010, 5'b11101, fv(N, H, N, N, N), 1'b0, 1'b0); step("t1_hdr",   5'b00010, 5'b00010, 1'b1, 3'd4, 1'b0);
    drive(5'b00010, 5'b11101, fv(N, P, N, N, N), 1'b0, 1'b0); step("t1_pay",   5'b00010, 5'b00010, 1'b1, 3'd3, 1'b0);
    drive(5'b00010, 5'b11101, fv(N, T, N, N, N), 1'b0, 1'b0); step("t1_tail",  5'b00010, 5'b00010, 1'b1, 3'd2, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b0, 1'b0); step("t1_done",  5'b00000, 5'b00000, 1'b0, 3'd1, 1'b0);

    // pointer sits at 2: input 2 beats input 0
    drive(5'b00101, 5'b11010, fv(H, N, H, N, N), 1'b0, 1'b0); step("ptr_arb",     5'b00000, 5'b00000, 1'b0, 3'd1, 1'b0);
    drive(5'b00101, 5'b11010, fv(H, N, T, N, N), 1'b0, 1'b0); step("ptr_grant2",  5'b00100, 5'b00100, 1'b1, 3'd1, 1'b0);
    // zero credits blocks arbitration
    drive(5'b00001, 5'b11110, fv(H, N, N, N, N), 1'b0, 1'b0); step("zero_cred",    5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    drive(5'b00001, 5'b11110, fv(H, N, N, N, N), 1'b1, 1'b0); step("zero_cred_ci", 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    drive(5'b00001, 5'b11110, fv(H, N, N, N, N), 1'b0, 1'b0); step("cred_arb",     5'b00000, 5'b00000, 1'b0, 3'd1, 1'b0);
    drive(5'b00001, 5'b11110, fv(T, N, N, N, N), 1'b0, 1'b0); step("g0_tail",      5'b00001, 5'b00001, 1'b1, 3'd1, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b0, 1'b1); step("rst_idle",     5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);

    // round robin over inputs 0, 2, 4 with credits returned alongside pops
    drive(5'b10101, 5'b01010, fv(H, N, H, N, H), 1'b0, 1'b0); step("rr_arb0",       5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b10101, 5'b01010, fv(H, N, H, N, H), 1'b1, 1'b0); step("rr_g0_hdr",     5'b00001, 5'b00001, 1'b1, 3'd4, 1'b0);
    drive(5'b10101, 5'b01010, fv(T, N, H, N, H), 1'b1, 1'b0); step("rr_g0_tail",    5'b00001, 5'b00001, 1'b1, 3'd4, 1'b0);
    drive(5'b10101, 5'b01010, fv(H, N, H, N, H), 1'b0, 1'b0); step("rr_arb2",       5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b10101, 5'b01010, fv(H, N, H, N, H), 1'b1, 1'b0); step("rr_g2_hdr",     5'b00100, 5'b00100, 1'b1, 3'd4, 1'b0);
    drive(5'b10101, 5'b01010, fv(H, N, T, N, H), 1'b1, 1'b0); step("rr_g2_tail",    5'b00100, 5'b00100, 1'b1, 3'd4, 1'b0);
    drive(5'b10001, 5'b01110, fv(H, N, N, N, H), 1'b0, 1'b0); step("rr_arb4",       5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b10001, 5'b01110, fv(H, N, N, N, H), 1'b1, 1'b0); step("rr_g4_hdr",     5'b10000, 5'b10000, 1'b1, 3'd4, 1'b0);
    drive(5'b10001, 5'b01110, fv(H, N, N, N, T), 1'b1, 1'b0); step("rr_g4_tail",    5'b10000, 5'b10000, 1'b1, 3'd4, 1'b0);
    drive(5'b00001, 5'b11110, fv(H, N, N, N, N), 1'b0, 1'b0); step("rr_arb0_again", 5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b00001, 5'b11110, fv(H, N, N, N, N), 1'b1, 1'b0); step("rr_g0_hdr2",    5'b00001, 5'b00001, 1'b1, 3'd4, 1'b0);
    drive(5'b00001, 5'b11110, fv(T, N, N, N, N), 1'b1, 1'b0); step("rr_g0_tail2",   5'b00001, 5'b00001, 1'b1, 3'd4, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b0, 1'b0); step("rr_end",        5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);

    // credit stall: 6-flit packet on input 3
    drive(5'b01000, 5'b10111, fv(N, N, N, H, N), 1'b0, 1'b0); step("cs_arb",            5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, H, N), 1'b0, 1'b0); step("cs_f1",             5'b01000, 5'b01000, 1'b1, 3'd4, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("cs_f2",             5'b01000, 5'b01000, 1'b1, 3'd3, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("cs_f3",             5'b01000, 5'b01000, 1'b1, 3'd2, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("cs_f4",             5'b01000, 5'b01000, 1'b1, 3'd1, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("cs_stall",          5'b01000, 5'b00000, 1'b1, 3'd0, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b1, 1'b0); step("cs_stall_ci",       5'b01000, 5'b00000, 1'b1, 3'd0, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b1, 1'b0); step("cs_pop_and_credit", 5'b01000, 5'b01000, 1'b1, 3'd1, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, T, N), 1'b0, 1'b0); step("cs_tail",           5'b01000, 5'b01000, 1'b1, 3'd1, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b1, 1'b0); step("cs_idle",           5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b1, 1'b0); step("cr_1",              5'b00000, 5'b00000, 1'b0, 3'd1, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b1, 1'b0); step("cr_2",              5'b00000, 5'b00000, 1'b0, 3'd2, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b1, 1'b0); step("cr_3",              5'b00000, 5'b00000, 1'b0, 3'd3, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b1, 1'b0); step("cr_overflow",       5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b0, 1'b0); step("err_set",           5'b00000, 5'b00000, 1'b0, 3'd4, 1'b1);
    drive(5'b00000, 5'b11111, fv(N, N, N, N, N), 1'b0, 1'b0); step("err_hold",          5'b00000, 5'b00000, 1'b0, 3'd4, 1'b1);

    // reset while locked on input 3, leftover payload must not win
    drive(5'b01000, 5'b10111, fv(N, N, N, H, N), 1'b0, 1'b0); step("rm_arb",       5'b00000, 5'b00000, 1'b0, 3'd4, 1'b1);
    drive(5'b01000, 5'b10111, fv(N, N, N, H, N), 1'b0, 1'b0); step("rm_g3",        5'b01000, 5'b01000, 1'b1, 3'd4, 1'b1);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b1); step("rm_rst",       5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("rm_after",     5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("rm_payload_1", 5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);
    drive(5'b01000, 5'b10111, fv(N, N, N, P, N), 1'b0, 1'b0); step("rm_payload_2", 5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port round-robin allocator for the 2D-mesh NoC router; one instance per output (N, E, W, S, L).
- Collects the routing requests that each input port's LBDR raises for this output and grants the output to one input for a whole packet (HEADER through TAIL).
- Drives the winner's input-FIFO read enable, gated by a downstream credit counter.
- Sits between the five input FIFO/LBDR pairs and the crossbar select for this output.

Parameters:
- NUM_IN, 5, number of requesting input ports; index 0=N, 1=E, 2=W, 3=S, 4=L.
- CREDITS, 4, downstream buffer depth; reset value and maximum of the credit counter.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_IN  req[i]=1 when input i's LBDR selects this output port.
- empty  input  NUM_IN  empty[i]=1 when input i's FIFO has no flit.
- flit_id  input  3*NUM_IN  flit type at the head of FIFO i, in bits [3i+2:3i]; encodings are `HEADER / `PAYLOAD / `TAIL from parameters.sv.
- credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
- grant  output  NUM_IN  one-hot crossbar select; all zero when idle.
- rd_en  output  NUM_IN  pop strobe to the granted input FIFO; at most one bit high.
- busy  output  1  high while the allocator is in LOCKED.
- credit_cnt  output  CW  current credit count.
- credit_err  output  1  sticky flag: credit_in received while credit_cnt==CREDITS.

Behaviour:
- States: IDLE, LOCKED; both state and grant are registered. busy = (state==LOCKED).
- Request eligibility: input i is eligible when req[i] & ~empty[i] & flit_id_i==`HEADER. PAYLOAD or TAIL flits never win arbitration.
- IDLE, arbitration:
  - Arbitration happens when any input is eligible and credit_cnt!=0.
  - Winner is the first eligible index scanning ptr, ptr+1, ..., wrapping modulo NUM_IN.
  - Next cycle: state=LOCKED, grant=onehot(winner), ptr=(winner+1) mod NUM_IN.
  - With no eligible input, or with credit_cnt==0: stay in IDLE, grant=0, ptr unchanged.
- Latency: a header visible at the FIFO head in cycle t gets grant in t+1. The header is popped in t+1 if credits remain.
- rd_en (combinational from registered state): rd_en[g] = LOCKED & grant[g] & ~empty[g] & (credit_cnt!=0). All other bits are 0.
- LOCKED:
  - The grant is held regardless of req.
  - If rd_en[g] is high and flit_id_g==`TAIL: next cycle state=IDLE, grant=0.
  - A new arbitration can fire in that following IDLE cycle, so there is one bubble cycle between packets.
- Empty FIFO or zero credits in LOCKED: rd_en=0 and the grant is held. There is no timeout.
- Credit counter:
  - rd_en pop alone: -1.
  - credit_in alone: +1.
  - Both in the same cycle: unchanged.
  - credit_in while credit_cnt==CREDITS: count stays at CREDITS and credit_err is set. credit_err is cleared only by rst.
  - Underflow cannot occur because rd_en is gated by credit_cnt!=0.
- Reset (including mid-packet) sets: state=IDLE, grant=0, ptr=0, credit_cnt=CREDITS, credit_err=0. rd_en is therefore 0.
- Arithmetic:
  - ptr is a modulo-NUM_IN counter; wrap 4 -> 0.
  - credit_cnt is unsigned CW bits and never exceeds CREDITS.

Test Plan:
- Single packet:
  - Stimulus: after reset, input 1 presents req[1]=1 with HEADER, then PAYLOAD, then TAIL, with no stalls.
  - Response: grant=5'b00010 one cycle after the header; rd_en[1] high for 3 consecutive cycles.
  - Response: credit_cnt goes 4->3->2->1; grant=0 the cycle after TAIL; ptr=2.
- Round-robin:
  - Stimulus: inputs 0, 2 and 4 all hold 2-flit packets (HEADER, TAIL), with credit_in returned every cycle.
  - Response: grant order is 0, 2, 4, 0; each packet lasts 2 LOCKED cycles followed by 1 IDLE cycle.
- Credit stall:
  - Stimulus: CREDITS=4, a 6-flit packet, no credit_in.
  - Response: 4 flits are popped, then rd_en=0 with grant held and busy=1.
  - Stimulus: two credit_in pulses.
  - Response: the remaining 2 flits are popped and the allocator returns to IDLE.
- Simultaneous pop and credit:
  - Stimulus: credit_in coincides with rd_en.
  - Response: credit_cnt unchanged.
  - Stimulus: credit_in at credit_cnt=4.
  - Response: credit_cnt stays 4 and credit_err=1 until rst.
- Reset mid-packet:
  - Stimulus: rst asserted while LOCKED on input 3 after its HEADER.
  - Response: next cycle grant=0, busy=0, credit_cnt=4.
  - Stimulus: the leftover PAYLOAD flit at input 3 with req[3]=1.
  - Response: no grant is issued.
